// File: rtl/alu_pkg.sv
// alu_acc shared package: op codes and FSM state encodings.
// Multiply support is selected with the ALU_MUL_EN macro.
package alu_pkg;

    localparam logic [2:0] ALU_OP_INC   = 3'd0;
    localparam logic [2:0] ALU_OP_ADD   = 3'd1;
    localparam logic [2:0] ALU_OP_ORXOR = 3'd2;
    localparam logic [2:0] ALU_OP_RED   = 3'd3;
    localparam logic [2:0] ALU_OP_LOAD  = 3'd4;
    localparam logic [2:0] ALU_OP_SHL   = 3'd5;
    localparam logic [2:0] ALU_OP_SHR   = 3'd6;
    localparam logic [2:0] ALU_OP_MUL   = 3'd7;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

endpackage

// File: rtl/alu_acc_if.sv
// alu_acc command/result bus: switch operand, op select, go strobe,
// accumulator result and busy/done status.
interface alu_acc_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   data_in;
    logic [2:0]         func;
    logic               go;
    logic [2*WIDTH-1:0] result;
    logic               busy;
    logic               done;

    modport master (
        output data_in, func, go,
        input  result, busy, done
    );

    modport slave (
        input  data_in, func, go,
        output result, busy, done
    );
endinterface

// File: rtl/seq_mult.sv
// Shift-add unsigned multiplier: WIDTH iterations after start,
// product shows the final value while last is high.
module seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               last
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_a;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_b;
    logic [CW-1:0]      r_cnt;
    logic               r_run;

    // r_a holds A << i and r_b holds B >> i for the current iteration i
    assign product = r_prod + (r_b[0] ? r_a : '0);
    assign last    = r_run && (r_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_a    <= '0;
            r_b    <= '0;
            r_prod <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
        end else if (start) begin
            r_a    <= (2*WIDTH)'(a);
            r_b    <= b;
            r_prod <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b1;
        end else if (r_run) begin
            r_prod <= product;
            r_a    <= r_a << 1;
            r_b    <= r_b >> 1;
            r_cnt  <= r_cnt + CW'(1);
            if (last) begin
                r_run <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_acc.sv
// Registered accumulator ALU; B is fed back from result[WIDTH-1:0].
// Define ALU_MUL_EN to build op 7 as a multi-cycle multiply.
module alu_acc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic resetn,
    alu_acc_if.slave bus
);
    localparam int RW = 2 * WIDTH;
    localparam int SW = $clog2(WIDTH);

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_add_b;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_c;
    logic [SW-1:0]    w_shamt;
    logic [RW-1:0]    w_alu;
    logic [RW-1:0]    r_result;
    logic             r_done;
    logic             w_busy;

    assign w_a     = bus.data_in;
    assign w_b     = r_result[WIDTH-1:0];
    assign w_shamt = w_a[SW-1:0];
    assign w_add_b = (bus.func == ALU_OP_INC) ? WIDTH'(1) : w_b;

    // ripple full-adder chain shared by INC and ADD
    assign w_c[0] = 1'b0;
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
        assign w_sum[gi]  = w_a[gi] ^ w_add_b[gi] ^ w_c[gi];
        assign w_c[gi+1]  = (w_a[gi] & w_add_b[gi]) |
                            (w_c[gi] & (w_a[gi] ^ w_add_b[gi]));
    end

    always_comb begin
        w_alu = '0;
        unique case (bus.func)
            ALU_OP_INC,
            ALU_OP_ADD:   w_alu = RW'({w_c[WIDTH], w_sum});
            ALU_OP_ORXOR: w_alu = {w_a | w_b, w_a ^ w_b};
            ALU_OP_RED:   w_alu[0] = (|w_a) | (|w_b);
            ALU_OP_LOAD:  w_alu = RW'(w_a);
            ALU_OP_SHL:   w_alu = RW'(w_b) << w_shamt;
            ALU_OP_SHR:   w_alu = RW'(w_b >> w_shamt);
            ALU_OP_MUL:   w_alu = '0;
            default:      w_alu = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    logic [0:0]    r_state;
    logic          w_start;
    logic          w_last;
    logic [RW-1:0] w_product;

    assign w_busy  = (r_state == S_MUL);
    assign w_start = bus.go && !w_busy && (bus.func == ALU_OP_MUL);

    seq_mult #(
        .WIDTH(WIDTH)
    ) u_mult (
        .clk     (clk),
        .resetn  (resetn),
        .start   (w_start),
        .a       (w_a),
        .b       (w_b),
        .product (w_product),
        .last    (w_last)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_MUL) begin
                if (w_last) begin
                    r_result <= w_product;
                    r_done   <= 1'b1;
                    r_state  <= S_IDLE;
                end
            end else if (bus.go) begin
                if (bus.func == ALU_OP_MUL) begin
                    r_state <= S_MUL;
                end else begin
                    r_result <= w_alu;
                    r_done   <= 1'b1;
                end
            end
        end
    end
`else
    assign w_busy = 1'b0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= bus.go;
            if (bus.go) begin
                r_result <= w_alu;
            end
        end
    end
`endif

    assign bus.result = r_result;
    assign bus.busy   = w_busy;
    assign bus.done   = r_done;
endmodule

// File: doc/alu_acc.md
# alu_acc

Parametrised, registered successor to the lab ALU. It takes a WIDTH-bit operand A from the switches, and its operand B is fed back from the low half of its own 2·WIDTH-bit result register, which makes the block a simple accumulator. It supports the same op classes as the combinational ALU, adds shifts, and adds a multi-cycle shift-add multiply under a go/busy/done handshake. It sits between the board inputs (switch operand, key-selected function) and the seven-segment and LED display logic.

## Interface
- WIDTH, 8, operand width; legal values are ≥4 and a multiple of 4. The result is 2·WIDTH bits.
- clk  input  1  system clock; every register is rising-edge.
- resetn  input  1  synchronous, active-low reset.
- data_in  input  WIDTH  operand A.
- func  input  3  op select; sampled only when a command is accepted.
- go  input  1  command strobe; a command is accepted on a rising edge where go=1 and busy=0.
- result  output  2·WIDTH  accumulator register. Operand B = result[WIDTH-1:0].
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse after any command completes.

## Operation
- Ops; all results are zero-extended to 2·WIDTH:
  - 0: A+1, with carry-out kept.
  - 1: A+B, with carry-out kept.
  - 2: {A|B, A^B}.
  - 3: reduction OR of A and B in bit 0.
  - 4: load A.
  - 5: B << A[$clog2(WIDTH)-1:0], 2·WIDTH-wide and unsigned.
  - 6: B >> A[$clog2(WIDTH)-1:0], logical.
  - 7: A·B, unsigned, multi-cycle.
- FSM states:
  - IDLE: an accepted op 0–6 writes result at that edge and stays in IDLE. An accepted op 7 latches A, B and the op, then goes to MUL.
  - MUL: runs WIDTH iterations. Iteration i adds (A << i) to the partial product when B[i]=1. On the last iteration it writes result and returns to IDLE.
- go while busy=1 is ignored, and is not queued.
- data_in and func changes during MUL have no effect, because the operands were latched at accept.
- result holds its value whenever no command completes.
- Arithmetic never overflows 2·WIDTH bits. The maximum product (2^W−1)^2 fits.

## Timing
- Reset values: result=0, busy=0, done=0, FSM=IDLE, multiplier registers=0.
- Reset during MUL aborts at that edge. result becomes 0 and no done is issued.
- Reset has priority over go on the same edge.
- Ops 0–6 are accepted at edge k, so result is valid after edge k and done=1 during cycle k→k+1.
- Op 7:
  - busy rises at the accept edge k.
  - result is written and busy falls at edge k+WIDTH.
  - done=1 for the cycle following edge k+WIDTH.
- Back-to-back commands: go may be held high. In IDLE a new command is accepted every edge, and done then stays high for consecutive completions.
- A go on the same edge that MUL finishes is ignored, because busy=1 at that edge. The next accept happens at the following edge.

## Configuration
- ALU_MUL_EN defined: op 7 is the multi-cycle multiply described above, and the multiplier sub-module is instantiated.
- ALU_MUL_EN undefined:
  - op 7 completes in one cycle like ops 0–6 and writes result=0.
  - busy is tied to 0.
  - no multiplier logic is instantiated.

## Structure
- Shared package alu_pkg holds:
  - op codes ALU_OP_INC, ALU_OP_ADD, ALU_OP_ORXOR, ALU_OP_RED, ALU_OP_LOAD, ALU_OP_SHL, ALU_OP_SHR, ALU_OP_MUL;
  - FSM state encodings S_IDLE and S_MUL.
- One sub-module, seq_mult, implements the shift-add multiplier. It has the same clk/resetn, plus start, a, b, product, and last.
- The adders reuse the existing ripple full-adder chain, generalised to WIDTH with a generate loop.

## Test plan
All scenarios use WIDTH=8.
- Reset: drive resetn=0 for 2 edges → result=16'h0000, busy=0, done=0. Then hold go=1 with resetn=0 → result stays 0.
- Load and add:
  - op4 with A=8'h0F → result=16'h000F, with done pulsed for one cycle.
  - Then op1 with A=8'hFF → result=16'h010E.
  - Then op0 with A=8'hFF → result=16'h0100.
- Logic ops:
  - After result=16'h000E, op2 with A=8'hA5 → result=16'hAFAB.
  - op3 with A=8'h00 and B=0x00 → result=16'h0000.
- Shifts:
  - Load 8'h81, then op5 with A=8'h03 → result=16'h0408.
  - Then op6 with A=8'h02 → result=16'h0002.
- Multiply:
  - Load 8'hFF, then op7 with A=8'hFF → busy is high for exactly 8 cycles, then result=16'hFE01 and done pulses once.
  - A go with op4 pulsed mid-multiply is ignored.
  - Without ALU_MUL_EN, the same op7 gives result=0 after 1 cycle with busy=0.
- Reset mid-multiply: assert resetn=0 at the 4th MUL cycle → result=0 and busy=0 at that edge, and done is never pulsed.
